// File: rtl/rr_arbiter_lock.sv
// N-way round-robin arbiter with registered one-hot/encoded grant and per-requester
// bus locking, bounded by MAX_HOLD consecutive cycles so a locked owner cannot starve others.
module rr_arbiter_lock #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] lock,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   last
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StLocked
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [7:0]         hold_q, hold_d;

    logic [IDX_W-1:0]   holder;
    logic [NUM_REQ-1:0] holder_oh;
    logic [NUM_REQ-1:0] arb_mask;
    logic [IDX_W-1:0]   winner;
    logic               keep;
    logic               holder_locked;

    // First asserted bit of mask searching last+1, last+2, ... and ending at ptr itself.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        logic             found;
        int               idx;
        win   = ptr;
        found = 1'b0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            idx  = (int'(ptr) + off) % int'(NUM_REQ);
            cand = IDX_W'(idx);
            if (!found && mask[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        holder            = grant_idx_q;
        holder_oh         = '0;
        holder_oh[holder] = 1'b1;
        holder_locked     = (state_q == StLocked) && req[holder] && lock[holder];
        keep              = 1'b0;
        arb_mask          = req;
        if (holder_locked) begin
            if (MAX_HOLD == 0 || int'(hold_q) < int'(MAX_HOLD) - 1) begin
                keep = 1'b1;
            end else if ((req & ~holder_oh) != '0) begin
                // Hold window expired: the owner steps aside if anyone else is waiting.
                arb_mask = req & ~holder_oh;
            end
        end
        winner = rr_pick(arb_mask, last_q);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        last_d        = last_q;
        hold_d        = hold_q;
        if (keep) begin
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        end else if (arb_mask == '0) begin
            state_d       = StIdle;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            hold_d        = 8'd0;
        end else begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            grant_idx_d     = winner;
            grant_valid_d   = 1'b1;
            last_d          = winner;
            hold_d          = 8'd0;
            state_d         = lock[winner] ? StLocked : StGrant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            last_q        <= IDX_W'(NUM_REQ - 1);
            hold_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            last_q        <= last_d;
            hold_q        <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign last        = last_q;

endmodule
